// File: rtl/alu_seq_pkg.sv
// ----------------------------------------------------------------------------
// alu_seq_pkg
// Shared types and constants for the alu_seq execute-stage ALU.
//   alu_op_t    : operation select, RV32I ALU ops followed by the eight RV32M ops
//   alu_state_t : result-handshake FSM states (IDLE, BUSY, DONE)
//   MULDIV_OPS  : one bit per alu_op_t code, set for the multiply/divide subset
//   is_muldiv() : looks an op up in MULDIV_OPS
// Codes 18..31 are left undefined and report as illegal.
// ----------------------------------------------------------------------------
package alu_seq_pkg;

    typedef enum logic [4:0] {
        OP_ADD    = 5'd0,
        OP_SUB    = 5'd1,
        OP_SLL    = 5'd2,
        OP_SLT    = 5'd3,
        OP_SLTU   = 5'd4,
        OP_XOR    = 5'd5,
        OP_SRL    = 5'd6,
        OP_SRA    = 5'd7,
        OP_OR     = 5'd8,
        OP_AND    = 5'd9,
        OP_MUL    = 5'd10,
        OP_MULH   = 5'd11,
        OP_MULHSU = 5'd12,
        OP_MULHU  = 5'd13,
        OP_DIV    = 5'd14,
        OP_DIVU   = 5'd15,
        OP_REM    = 5'd16,
        OP_REMU   = 5'd17
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } alu_state_t;

    // Bits 10..17 mark MUL..REMU.
    localparam logic [31:0] MULDIV_OPS = 32'h0003_FC00;

    function automatic logic is_muldiv(alu_op_t op);
        return MULDIV_OPS[op];
    endfunction

endpackage

// File: rtl/alu_muldiv.sv
// ----------------------------------------------------------------------------
// alu_muldiv
// Iterative radix-2 RV32M multiply/divide unit. Only built into alu_seq when
// ALU_MULDIV_EN is defined.
//   clk, rst : clock, asynchronous active-low reset
//   start    : load op/a/b and begin; overrides any operation in progress
//   op       : one of MUL..REMU
//   a, b     : raw operands (dividend/divisor for divides)
//   busy     : an operation is iterating
//   done     : combinational, high in the final busy cycle; result valid then
//   result   : final value, meaningful only while done is high
// Operands are converted to magnitudes on entry and the sign is restored on
// exit, so both the shift-add multiplier and the restoring divider run
// unsigned. The last of the XLEN steps is not registered: it is computed
// combinationally in the done cycle so the caller can capture the result on
// the same edge that ends the busy period.
// ----------------------------------------------------------------------------
module alu_muldiv
    import alu_seq_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  alu_op_t         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int SHW = $clog2(XLEN);

    logic                busy_q;
    logic [SHW-1:0]      cnt_q;
    alu_op_t             op_q;
    logic [XLEN-1:0]     mag_a_q;
    logic [XLEN-1:0]     mag_b_q;
    logic [XLEN-1:0]     a_raw_q;
    logic                neg_q;
    logic                neg_rem_q;
    logic                b_zero_q;
    logic [2*XLEN-1:0]   prod_q;
    logic [XLEN-1:0]     rem_q;
    logic [XLEN-1:0]     quo_q;

    logic                sign_a;
    logic                sign_b;
    logic [XLEN-1:0]     mag_a;
    logic [XLEN-1:0]     mag_b;
    logic                last;

    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   prod_d;
    logic [XLEN:0]       div_shift;
    logic [XLEN-1:0]     rem_d;
    logic [XLEN-1:0]     quo_d;
    logic [2*XLEN-1:0]   prod_fix;
    logic [XLEN-1:0]     quo_fix;
    logic [XLEN-1:0]     rem_fix;

    // Entry sign handling: which operands are treated as signed for this op.
    always_comb begin
        sign_a = a[XLEN-1] && (op == OP_MULH || op == OP_MULHSU ||
                               op == OP_DIV  || op == OP_REM);
        sign_b = b[XLEN-1] && (op == OP_MULH || op == OP_DIV || op == OP_REM);
        mag_a  = sign_a ? -a : a;
        mag_b  = sign_b ? -b : b;
    end

    assign last = (cnt_q == SHW'(XLEN - 1));
    assign busy = busy_q;
    assign done = busy_q && last;

    // One multiply step and one restoring-divide step from the current state.
    always_comb begin
        mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mag_a_q} : '0);
        prod_d    = {mul_sum, prod_q[XLEN-1:1]};
        div_shift = {rem_q, quo_q[XLEN-1]};
        if (div_shift >= {1'b0, mag_b_q}) begin
            rem_d = XLEN'(div_shift - {1'b0, mag_b_q});
            quo_d = {quo_q[XLEN-2:0], 1'b1};
        end else begin
            rem_d = div_shift[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b0};
        end
    end

    // Exit sign fix-up plus the RISC-V divide-by-zero convention. Signed
    // overflow (MIN / -1) needs no special case: the magnitude quotient 2^(XLEN-1)
    // negates back to MIN and the remainder is 0.
    always_comb begin
        prod_fix = neg_q ? -prod_d : prod_d;
        quo_fix  = neg_q ? -quo_d : quo_d;
        rem_fix  = neg_rem_q ? -rem_d : rem_d;
        result   = '0;
        case (op_q)
            OP_MUL:                         result = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:   result = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:                result = b_zero_q ? '1 : quo_fix;
            OP_REM, OP_REMU:                result = b_zero_q ? a_raw_q : rem_fix;
            default:                        result = '0;
        endcase
    end

    // Operand load on start, then one registered step per busy cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            op_q      <= OP_MUL;
            mag_a_q   <= '0;
            mag_b_q   <= '0;
            a_raw_q   <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            b_zero_q  <= 1'b0;
            prod_q    <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
        end else if (start) begin
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            op_q      <= op;
            mag_a_q   <= mag_a;
            mag_b_q   <= mag_b;
            a_raw_q   <= a;
            neg_q     <= sign_a ^ sign_b;
            neg_rem_q <= sign_a;
            b_zero_q  <= (b == '0);
            prod_q    <= {{XLEN{1'b0}}, mag_b};
            rem_q     <= '0;
            quo_q     <= mag_a;
        end else if (busy_q) begin
            prod_q <= prod_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            cnt_q  <= cnt_q + SHW'(1);
            if (last) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// ----------------------------------------------------------------------------
// alu_seq
// Execute-stage integer ALU with valid/ready handshakes on both sides and a
// registered result. Full RV32I ALU op set; every op except SUB may take its
// second operand from imm_i.
// Optional feature macro: ALU_MULDIV_EN -- when defined, the RV32M ops run on
// the iterative alu_muldiv unit (XLEN+1 cycle latency); otherwise they finish
// in one cycle with rd_data=0 and illegal=1.
//   clk, rst           : clock, asynchronous active-low reset
//   flush              : drop whatever is in flight, return to IDLE
//   in_valid/in_ready  : op acceptance handshake
//   alu_op, is_imm     : operation and operand-B select
//   rs1_data, rs2_data : register operands
//   imm_i              : sign-extended immediate
//   out_valid/out_ready: result handshake
//   rd_data, illegal   : registered result and its qualifier
// XLEN must be a power of two and at least 8.
// ----------------------------------------------------------------------------
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  alu_op_t         alu_op,
    input  logic            is_imm,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm_i,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] rd_data,
    output logic            illegal
);

    localparam int SHW = $clog2(XLEN);

    alu_state_t      state_q, state_d;
    logic [XLEN-1:0] rd_q, rd_d;
    logic            ill_q, ill_d;
    logic            accept;

    logic [XLEN-1:0] op_b;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] sc_result;
    logic            sc_illegal;

`ifdef ALU_MULDIV_EN
    logic            md_start;
    logic            md_busy;
    logic            md_done;
    logic [XLEN-1:0] md_result;

    alu_muldiv #(
        .XLEN (XLEN)
    ) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (md_start),
        .op     (alu_op),
        .a      (rs1_data),
        .b      (op_b),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_result)
    );
`endif

    // A consumed result frees the register in the same cycle, which is what
    // allows one single-cycle op per clock. A flush blocks acceptance.
    assign in_ready  = !flush && ((state_q == IDLE) || (state_q == DONE && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign rd_data   = rd_q;
    assign illegal   = ill_q;

    // Single-cycle datapath. SUB always subtracts rs2_data.
    always_comb begin
        op_b       = is_imm ? imm_i : rs2_data;
        shamt      = op_b[SHW-1:0];
        sc_result  = '0;
        sc_illegal = 1'b0;
        case (alu_op)
            OP_ADD:  sc_result = rs1_data + op_b;
            OP_SUB:  sc_result = rs1_data - rs2_data;
            OP_SLL:  sc_result = rs1_data << shamt;
            OP_SLT:  sc_result = {{(XLEN-1){1'b0}}, ($signed(rs1_data) < $signed(op_b))};
            OP_SLTU: sc_result = {{(XLEN-1){1'b0}}, (rs1_data < op_b)};
            OP_XOR:  sc_result = rs1_data ^ op_b;
            OP_SRL:  sc_result = rs1_data >> shamt;
            OP_SRA:  sc_result = $unsigned($signed(rs1_data) >>> shamt);
            OP_OR:   sc_result = rs1_data | op_b;
            OP_AND:  sc_result = rs1_data & op_b;
            default: sc_illegal = 1'b1;
        endcase
    end

    // Next-state and result-register update. Flush wins over everything.
    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        ill_d   = ill_q;
`ifdef ALU_MULDIV_EN
        md_start = 1'b0;
`endif
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (state_q == DONE && out_ready) begin
                        state_d = IDLE;
                    end
                    if (accept) begin
`ifdef ALU_MULDIV_EN
                        if (is_muldiv(alu_op)) begin
                            state_d  = BUSY;
                            md_start = 1'b1;
                        end else begin
                            state_d = DONE;
                            rd_d    = sc_result;
                            ill_d   = sc_illegal;
                        end
`else
                        state_d = DONE;
                        rd_d    = sc_result;
                        ill_d   = sc_illegal;
`endif
                    end
                end
                BUSY: begin
`ifdef ALU_MULDIV_EN
                    if (md_busy && md_done) begin
                        state_d = DONE;
                        rd_d    = md_result;
                        ill_d   = 1'b0;
                    end
`else
                    state_d = IDLE;
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            rd_q    <= '0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            ill_q   <= ill_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// ----------------------------------------------------------------------------
// tb_alu_seq
// Self-checking bench for alu_seq at XLEN=32. Expected values come from a
// behavioural model written with plain integer arithmetic. Honours
// ALU_MULDIV_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int XLEN = 32;
`ifdef ALU_MULDIV_EN
    localparam int MD_LAT = XLEN + 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    alu_op_t     alu_op = OP_ADD;
    logic        is_imm = 1'b0;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic [31:0] imm_i = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] rd_data;
    logic        illegal;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    alu_seq #(
        .XLEN (XLEN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .is_imm    (is_imm),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .imm_i     (imm_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rd_data   (rd_data),
        .illegal   (illegal)
    );

    // Behavioural reference: results straight from the arithmetic definitions.
    function automatic void ref_alu(input alu_op_t op, input logic [31:0] a,
                                    input logic [31:0] rs2, input logic [31:0] imm,
                                    input bit use_imm, output logic [31:0] res,
                                    output bit ill);
        logic [31:0] b;
        longint      d;
        longint      sa;
        logic [63:0] p;
        b   = (use_imm && op != OP_SUB) ? imm : rs2;
        d   = 1;
        for (int i = 0; i < int'(b % 32); i++) d = d * 2;
        res = '0;
        ill = 1'b0;
        case (op)
            OP_ADD:  res = a + b;
            OP_SUB:  res = a - rs2;
            OP_SLL:  res = 32'(longint'({32'b0, a}) * d);
            OP_SLT:  res = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            OP_SLTU: res = (a < b) ? 32'd1 : 32'd0;
            OP_XOR:  res = a ^ b;
            OP_SRL:  res = 32'(longint'({32'b0, a}) / d);
            OP_SRA: begin
                sa = longint'(int'(a));
                if (sa >= 0) res = 32'(sa / d);
                else         res = 32'(-((-sa + d - 1) / d));
            end
            OP_OR:   res = a | b;
            OP_AND:  res = a & b;
`ifdef ALU_MULDIV_EN
            OP_MUL:    res = a * b;
            OP_MULH: begin
                p = 64'(longint'(int'(a)) * longint'(int'(b)));
                res = p[63:32];
            end
            OP_MULHSU: begin
                p = 64'(longint'(int'(a)) * longint'({32'b0, b}));
                res = p[63:32];
            end
            OP_MULHU: begin
                p = {32'b0, a} * {32'b0, b};
                res = p[63:32];
            end
            OP_DIV: begin
                if (b == 0)                                  res = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == '1)      res = 32'h8000_0000;
                else                                         res = 32'(int'(a) / int'(b));
            end
            OP_DIVU: res = (b == 0) ? 32'hFFFF_FFFF : a / b;
            OP_REM: begin
                if (b == 0)                                  res = a;
                else if (a == 32'h8000_0000 && b == '1)      res = 32'd0;
                else                                         res = 32'(int'(a) % int'(b));
            end
            OP_REMU: res = (b == 0) ? a : a % b;
`endif
            default: ill = 1'b1;
        endcase
    endfunction

    // Presents one op with out_ready=1, waits for acceptance and the result,
    // then lets the result be consumed. Returns latency and observed outputs.
    task automatic applyStimulus(input alu_op_t op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] imm,
                                 input bit use_imm, output int lat,
                                 output logic [31:0] rd, output logic ill,
                                 output logic rdy);
        int w;
        alu_op    = op;
        rs1_data  = a;
        rs2_data  = b;
        imm_i     = imm;
        is_imm    = use_imm;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        #1;
        w = 0;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            #1;
            w++;
        end
        rdy = in_ready;
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
        end while (!out_valid && lat < 100);
        rd  = rd_data;
        ill = illegal;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        nvec++; if (rd_data !== 32'd0) begin nerr++; $display("[TB] FAIL reset_rd_data: got %h expected 00000000", rd_data); end
        nvec++; if (illegal !== 1'b0) begin nerr++; $display("[TB] FAIL reset_illegal: got %b expected 0", illegal); end
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
        rst = 1'b1;
        @(negedge clk);
        #1;
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("[TB] FAIL post_reset_out_valid: got %b expected 0", out_valid); end
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("[TB] FAIL post_reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_basic;
        alu_op_t     ops[6] = '{OP_SUB, OP_SLT, OP_SLTU, OP_SRA, OP_ADD, OP_SUB};
        logic [31:0] av[6]  = '{32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'd10, 32'd10};
        logic [31:0] bv[6]  = '{32'd7, 32'd1, 32'd1, 32'd4, 32'd0, 32'd4};
        logic [31:0] iv[6]  = '{32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFD, 32'd100};
        bit          imv[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] ev[6]  = '{32'hFFFF_FFFE, 32'd1, 32'd0, 32'hF800_0000, 32'd7, 32'd6};
        int lat; logic [31:0] rd; logic ill; logic rdy;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(ops[i], av[i], bv[i], iv[i], imv[i], lat, rd, ill, rdy);
            nvec++; if (rd !== ev[i]) begin nerr++; $display("[TB] FAIL basic_%0d_rd: got %h expected %h", i, rd, ev[i]); end
            nvec++; if (lat != 1) begin nerr++; $display("[TB] FAIL basic_%0d_latency: got %0d expected 1", i, lat); end
            nvec++; if (ill !== 1'b0) begin nerr++; $display("[TB] FAIL basic_%0d_illegal: got %b expected 0", i, ill); end
        end
    endtask

    task automatic test_random_single;
        alu_op_t op; logic [31:0] a, b, imm, exp; bit use_imm, eill;
        int lat; logic [31:0] rd; logic ill; logic rdy;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) op = alu_op_t'(5'($urandom_range(18, 31)));
            else                           op = alu_op_t'(5'($urandom_range(0, 9)));
            a = $urandom; b = $urandom; imm = $urandom;
            if ($urandom_range(0, 3) == 0) a = 32'h8000_0000;
            use_imm = 1'($urandom_range(0, 1));
            ref_alu(op, a, b, imm, use_imm, exp, eill);
            applyStimulus(op, a, b, imm, use_imm, lat, rd, ill, rdy);
            nvec++; if (rd !== exp) begin nerr++; $display("[TB] FAIL rand_%0d_rd op=%0d: got %h expected %h", i, op, rd, exp); end
            nvec++; if (ill !== eill) begin nerr++; $display("[TB] FAIL rand_%0d_illegal op=%0d: got %b expected %b", i, op, ill, eill); end
            nvec++; if (lat != 1) begin nerr++; $display("[TB] FAIL rand_%0d_latency: got %0d expected 1", i, lat); end
            nvec++; if (rdy !== 1'b1) begin nerr++; $display("[TB] FAIL rand_%0d_in_ready: got %b expected 1", i, rdy); end
        end
    endtask

    task automatic test_back_to_back;
        localparam int N = 12;
        logic [31:0] exp[N]; bit eill[N];
        alu_op_t op; logic [31:0] a, b;
        out_ready = 1'b1;
        is_imm    = 1'b0;
        for (int k = 0; k < N; k++) begin
            op = alu_op_t'(5'($urandom_range(0, 9)));
            a = $urandom; b = $urandom;
            ref_alu(op, a, b, 32'd0, 1'b0, exp[k], eill[k]);
            alu_op = op; rs1_data = a; rs2_data = b; in_valid = 1'b1;
            #1;
            nvec++; if (in_ready !== 1'b1) begin nerr++; $display("[TB] FAIL b2b_%0d_in_ready: got %b expected 1", k, in_ready); end
            @(posedge clk);
            @(negedge clk);
            nvec++; if (out_valid !== 1'b1) begin nerr++; $display("[TB] FAIL b2b_%0d_out_valid: got %b expected 1", k, out_valid); end
            nvec++; if (rd_data !== exp[k]) begin nerr++; $display("[TB] FAIL b2b_%0d_rd: got %h expected %h", k, rd_data, exp[k]); end
        end
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("[TB] FAIL b2b_drain_out_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_backpressure;
        alu_op = OP_ADD; rs1_data = 32'd1; rs2_data = 32'd1; is_imm = 1'b0;
        out_ready = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        alu_op = OP_SUB; rs1_data = 32'd9; rs2_data = 32'd3;
        for (int c = 0; c < 5; c++) begin
            #1;
            nvec++; if (out_valid !== 1'b1) begin nerr++; $display("[TB] FAIL bp_%0d_out_valid: got %b expected 1", c, out_valid); end
            nvec++; if (rd_data !== 32'd2) begin nerr++; $display("[TB] FAIL bp_%0d_rd: got %h expected 00000002", c, rd_data); end
            nvec++; if (in_ready !== 1'b0) begin nerr++; $display("[TB] FAIL bp_%0d_in_ready: got %b expected 0", c, in_ready); end
            if (c < 4) @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("[TB] FAIL bp_release_in_ready: got %b expected 1", in_ready); end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        nvec++; if (out_valid !== 1'b1) begin nerr++; $display("[TB] FAIL bp_next_out_valid: got %b expected 1", out_valid); end
        nvec++; if (rd_data !== 32'd6) begin nerr++; $display("[TB] FAIL bp_next_rd: got %h expected 00000006", rd_data); end
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_muldiv;
        int lat; logic [31:0] rd; logic ill; logic rdy;
`ifdef ALU_MULDIV_EN
        alu_op_t     ops[4] = '{OP_MULHU, OP_DIV, OP_DIVU, OP_REM};
        logic [31:0] av[4]  = '{32'hFFFF_FFFF, 32'h8000_0000, 32'd7, 32'd7};
        logic [31:0] bv[4]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
        logic [31:0] ev[4]  = '{32'hFFFF_FFFE, 32'h8000_0000, 32'hFFFF_FFFF, 32'd7};
        alu_op_t op; logic [31:0] a, b, exp; bit eill;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(ops[i], av[i], bv[i], 32'd0, 1'b0, lat, rd, ill, rdy);
            nvec++; if (rd !== ev[i]) begin nerr++; $display("[TB] FAIL md_%0d_rd: got %h expected %h", i, rd, ev[i]); end
            nvec++; if (lat != MD_LAT) begin nerr++; $display("[TB] FAIL md_%0d_latency: got %0d expected %0d", i, lat, MD_LAT); end
            nvec++; if (ill !== 1'b0) begin nerr++; $display("[TB] FAIL md_%0d_illegal: got %b expected 0", i, ill); end
        end
        for (int i = 0; i < 16; i++) begin
            op = alu_op_t'(5'($urandom_range(10, 17)));
            a = pick_operand(); b = pick_operand();
            ref_alu(op, a, b, 32'd0, 1'b0, exp, eill);
            applyStimulus(op, a, b, 32'd0, 1'b0, lat, rd, ill, rdy);
            nvec++; if (rd !== exp) begin nerr++; $display("[TB] FAIL mdrand_%0d_rd op=%0d a=%h b=%h: got %h expected %h", i, op, a, b, rd, exp); end
            nvec++; if (lat != MD_LAT) begin nerr++; $display("[TB] FAIL mdrand_%0d_latency: got %0d expected %0d", i, lat, MD_LAT); end
        end
`else
        applyStimulus(OP_MUL, 32'd3, 32'd4, 32'd0, 1'b0, lat, rd, ill, rdy);
        nvec++; if (rd !== 32'd0) begin nerr++; $display("[TB] FAIL nomd_rd: got %h expected 00000000", rd); end
        nvec++; if (ill !== 1'b1) begin nerr++; $display("[TB] FAIL nomd_illegal: got %b expected 1", ill); end
        nvec++; if (lat != 1) begin nerr++; $display("[TB] FAIL nomd_latency: got %0d expected 1", lat); end
`endif
    endtask

    // Common tail after an abort: nothing stale emerges and ADD 2+2 works.
    task automatic check_recovery(input string tag);
        int lat; logic [31:0] rd; logic ill; logic rdy; int seen;
        #1;
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("[TB] FAIL %s_out_valid: got %b expected 0", tag, out_valid); end
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("[TB] FAIL %s_in_ready: got %b expected 1", tag, in_ready); end
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        nvec++; if (seen != 0) begin nerr++; $display("[TB] FAIL %s_stale: got %0d valid cycles expected 0", tag, seen); end
        applyStimulus(OP_ADD, 32'd2, 32'd2, 32'd0, 1'b0, lat, rd, ill, rdy);
        nvec++; if (rd !== 32'd4) begin nerr++; $display("[TB] FAIL %s_add_rd: got %h expected 00000004", tag, rd); end
        nvec++; if (lat != 1) begin nerr++; $display("[TB] FAIL %s_add_latency: got %0d expected 1", tag, lat); end
    endtask

    task automatic test_abort;
        // Flush while holding a result (DONE, out_ready=0), new op offered too.
        alu_op = OP_ADD; rs1_data = 32'd5; rs2_data = 32'd5; is_imm = 1'b0;
        out_ready = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rs1_data = 32'd9; rs2_data = 32'd9; flush = 1'b1;
        #1;
        nvec++; if (out_valid !== 1'b1) begin nerr++; $display("[TB] FAIL flush_done_pre_valid: got %b expected 1", out_valid); end
        nvec++; if (in_ready !== 1'b0) begin nerr++; $display("[TB] FAIL flush_done_in_ready: got %b expected 0", in_ready); end
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        check_recovery("flush_done");

        // Async reset while holding a result.
        alu_op = OP_ADD; rs1_data = 32'd6; rs2_data = 32'd6;
        out_ready = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("[TB] FAIL rst_done_async_valid: got %b expected 0", out_valid); end
        nvec++; if (rd_data !== 32'd0) begin nerr++; $display("[TB] FAIL rst_done_async_rd: got %h expected 00000000", rd_data); end
        @(negedge clk);
        rst = 1'b1; out_ready = 1'b1;
        check_recovery("rst_done");

`ifdef ALU_MULDIV_EN
        // Flush and reset at BUSY cycle 10 of a divide.
        for (int k = 0; k < 2; k++) begin
            alu_op = OP_DIV; rs1_data = 32'd100; rs2_data = 32'd7;
            out_ready = 1'b1; in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            repeat (9) @(negedge clk);
            #1;
            nvec++; if (in_ready !== 1'b0) begin nerr++; $display("[TB] FAIL busy_%0d_in_ready: got %b expected 0", k, in_ready); end
            if (k == 0) begin
                flush = 1'b1;
                @(posedge clk);
                @(negedge clk);
                flush = 1'b0;
                check_recovery("flush_busy");
            end else begin
                rst = 1'b0;
                #1;
                nvec++; if (out_valid !== 1'b0) begin nerr++; $display("[TB] FAIL rst_busy_async_valid: got %b expected 0", out_valid); end
                @(negedge clk);
                rst = 1'b1;
                check_recovery("rst_busy");
            end
        end
`endif
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_random_single();
        test_back_to_back();
        test_backpressure();
        test_muldiv();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
